// File: rtl/carry_save_pkg.sv
// carry_save_pkg: shared state enum, beat counter width and operand extension helper
package carry_save_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;
  localparam int BEAT_W = 16;
  function automatic logic [63:0] extend(input logic [63:0] v, input int n, input bit sgn);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (i < n) ? v[i] : (sgn & v[n-1]);
    return r;
  endfunction
endpackage

// File: rtl/csa_layer.sv
// csa_layer: 3:2 compression of a, b, c (W bits) into sum and unshifted carry
module csa_layer #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(carry[i]));
  end
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder (a, b, ci -> s, co)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/carry_save_accumulator.sv
// carry_save_accumulator: K operands/beat into a carry-save total, resolved after in_last (clk, rst, in_* stream, clear, out_* result)
module carry_save_accumulator
  import carry_save_pkg::*;
#(
  parameter int N      = 8,
  parameter int K      = 3,
  parameter int ACC_W  = 16,
  parameter bit SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*N-1:0]    in_data,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats
);
  state_t state, state_next;
  logic [ACC_W-1:0] sum_r, carry_r;
  logic [BEAT_W-1:0] cnt;
  logic [ACC_W-1:0] ext [K];
  logic [ACC_W-1:0] ps [K+1];
  logic [ACC_W-1:0] pc [K+1];
  logic [ACC_W-1:0] lc [K];
  assign ps[0] = sum_r;
  assign pc[0] = carry_r;
  for (genvar j = 0; j < K; j++) begin : g_tree
    assign ext[j] = ACC_W'(extend(64'(in_data[j*N +: N]), N, SIGNED));
    csa_layer #(.W(ACC_W)) u_csa (
      .a(ps[j]), .b(pc[j]), .c(ext[j]), .sum(ps[j+1]), .carry(lc[j])
    );
    assign pc[j+1] = lc[j] << 1;
  end
  assign in_ready  = (state == ACCUM) && !clear;
  assign out_valid = (state == HOLD);
  always_comb begin
    state_next = state;
    state_next = (state == ACCUM) ? ((in_ready && in_valid && in_last) ? RESOLVE : ACCUM) :
                 (state == RESOLVE) ? HOLD : (out_ready ? ACCUM : HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      sum_r     <= '0;
      carry_r   <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_beats <= '0;
    end else begin
      state <= state_next;
      if ((state == ACCUM && clear) || (state == HOLD && out_ready)) begin
        sum_r   <= '0;
        carry_r <= '0;
        cnt     <= '0;
      end else if (state == ACCUM && in_valid) begin
        sum_r   <= ps[K];
        carry_r <= pc[K];
        cnt     <= (&cnt) ? cnt : cnt + 1'b1;
      end
      if (state == RESOLVE) begin
        out_sum   <= sum_r + carry_r;
        out_beats <= cnt;
      end
    end
  end
endmodule
